led_animator: RTL

Parametrised LED pattern generator for the DE2 board top level, driving `LEDR`/`LEDG` banks. It generalises the single ping-pong LED shifter to any bank width, with four selectable animation modes. It also adds a programmable step prescaler, an enable, and step/wrap status pulses. It sits between the board switches (mode/speed select) and the LED outputs, clocked from `CLOCK_50`.

---
 rtl/led_animator_if.sv | 23 ++
 rtl/led_animator.sv | 121 ++++++++++++
 2 files changed

// File: rtl/led_animator_if.sv
// Control and status bundle between the board-level driver and the LED animator.
interface led_animator_if #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DIV_W = 24
);
    logic             iEN;
    logic [1:0]       iMODE;
    logic [DIV_W-1:0] iDIV;
    logic [WIDTH-1:0] oLEDS;
    logic             oDIR;
    logic             oSTEP;
    logic             oWRAP;

    modport master (
        output iEN, iMODE, iDIV,
        input  oLEDS, oDIR, oSTEP, oWRAP
    );

    modport slave (
        input  iEN, iMODE, iDIV,
        output oLEDS, oDIR, oSTEP, oWRAP
    );
endinterface

// File: rtl/led_animator.sv
// Parametrised LED pattern generator: bounce, rotate-left, rotate-right and fill/drain bar,
// stepped by a programmable prescaler, with step and wrap status pulses.
module led_animator #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DIV_W = 24
) (
    input logic           iCLK,
    input logic           iRST_N,
    led_animator_if.slave bus
);

    typedef enum logic [1:0] {
        ModeBounce = 2'd0,
        ModeRotL   = 2'd1,
        ModeRotR   = 2'd2,
        ModeFill   = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] LedsOne = WIDTH'(1);
    localparam logic [WIDTH-1:0] LedsTop = LedsOne << (WIDTH - 1);

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] leds_q, init_leds, step_leds;
    logic [DIV_W-1:0] cnt_q;
    logic             dir_q, step_q, wrap_q;
    logic             step_dir, step_wrap;
    logic             mode_chg, tick;

    assign mode_d   = mode_e'(bus.iMODE);
    assign mode_chg = (mode_d != mode_q);
    assign tick     = bus.iEN && (cnt_q == bus.iDIV);

    always_comb begin
        init_leds = LedsOne;
        unique case (mode_d)
            ModeRotR: init_leds = LedsTop;
            ModeFill: init_leds = '0;
            default:  init_leds = LedsOne;
        endcase
    end

    // Next pattern, direction and wrap flag assuming the current cycle is a tick.
    always_comb begin
        step_leds = leds_q;
        step_dir  = dir_q;
        step_wrap = 1'b0;
        unique case (mode_q)
            ModeBounce: begin
                if (!dir_q) begin
                    step_leds = leds_q << 1;
                    step_dir  = step_leds[WIDTH-1];
                end else begin
                    step_leds = leds_q >> 1;
                    if (step_leds[0]) begin
                        step_dir  = 1'b0;
                        step_wrap = 1'b1;
                    end
                end
            end
            ModeRotL: begin
                step_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                step_wrap = (step_leds == LedsOne);
            end
            ModeRotR: begin
                step_leds = {leds_q[0], leds_q[WIDTH-1:1]};
                step_dir  = 1'b1;
                step_wrap = (step_leds == LedsTop);
            end
            ModeFill: begin
                if (!dir_q) begin
                    step_leds = {leds_q[WIDTH-2:0], 1'b1};
                    step_dir  = &step_leds;
                end else begin
                    step_leds = leds_q >> 1;
                    if (step_leds == '0) begin
                        step_dir  = 1'b0;
                        step_wrap = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            mode_q <= ModeBounce;
            leds_q <= LedsOne;
            dir_q  <= 1'b0;
            cnt_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            // A mode change wins over a tick and ignores the enable.
            if (mode_chg) begin
                mode_q <= mode_d;
                leds_q <= init_leds;
                dir_q  <= 1'b0;
                cnt_q  <= '0;
            end else if (bus.iEN) begin
                if (tick) begin
                    cnt_q  <= '0;
                    leds_q <= step_leds;
                    dir_q  <= step_dir;
                    step_q <= 1'b1;
                    wrap_q <= step_wrap;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.oLEDS = leds_q;
    assign bus.oDIR  = dir_q;
    assign bus.oSTEP = step_q;
    assign bus.oWRAP = wrap_q;

endmodule
